// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared FSM state type and default geometry for the boot loader.
package boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE, ERROR} state_e;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MEM_DEPTH  = 8192;
endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: drops one byte into its lane of the word being assembled and
// reports which lanes hold valid bytes, honouring the configured endianness.
module boot_word_packer
  import boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int LW         = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0]   word_i,
  input  logic [LW-1:0]           lane_i,
  input  logic [7:0]              byte_i,
  output logic [DATA_WIDTH-1:0]   word_o,
  output logic [DATA_WIDTH/8-1:0] mask_o
);
  localparam int LANES = DATA_WIDTH / 8;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int P = BIG_ENDIAN ? LANES - 1 - i : i;
    assign word_o[8*P +: 8] = (lane_i == LW'(i)) ? byte_i : word_i[8*P +: 8];
    assign mask_o[P]        = lane_i >= LW'(i);
  end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams an image byte-by-byte into word memory, then releases the CPU.
// Overflow past MEM_DEPTH bytes aborts the load and keeps the CPU in reset.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  input  logic                    s_last,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  output logic                    cpu_rst,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH:0]     byte_count
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int LW    = $clog2(LANES);
  state_e                  state_q;
  logic [LW-1:0]           lane_q;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [LANES-1:0]        mask_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic                    mem_en_q;
  logic [LANES-1:0]        mem_wr_en_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_din_q;
  logic                    full;
  assign full = count_q == (ADDR_WIDTH + 1)'(MEM_DEPTH);
  boot_word_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BIG_ENDIAN(BIG_ENDIAN),
    .LW        (LW)
  ) u_packer (
    .word_i(word_q),
    .lane_i(lane_q),
    .byte_i(s_data),
    .word_o(word_d),
    .mask_o(mask_d)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= '0;
      case (state_q)
        IDLE, DONE, ERROR: if (start) begin
          state_q <= LOAD;
          lane_q  <= '0;
          word_q  <= '0;
          addr_q  <= '0;
          count_q <= '0;
        end
        LOAD: if (s_valid) begin
          if (full) state_q <= ERROR;
          else begin
            count_q <= count_q + (ADDR_WIDTH + 1)'(1);
            // A completed word and the final partial word share one write path;
            // the lane mask already covers exactly the lanes filled so far.
            if (s_last || lane_q == LW'(LANES - 1)) begin
              mem_en_q    <= 1'b1;
              mem_wr_en_q <= mask_d;
              mem_addr_q  <= addr_q;
              mem_din_q   <= word_d;
              word_q      <= '0;
              lane_q      <= '0;
              addr_q      <= addr_q + ADDR_WIDTH'(LANES);
            end else begin
              word_q <= word_d;
              lane_q <= lane_q + LW'(1);
            end
            if (s_last) state_q <= FLUSH;
          end
        end
        FLUSH:   state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign s_ready    = state_q == LOAD;
  assign cpu_rst    = state_q != DONE;
  assign done       = state_q == DONE;
  assign error      = state_q == ERROR;
  assign byte_count = count_q;
  assign mem_en     = mem_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
endmodule
